mdu_iter: RTL and testbench
===========================

# mdu_iter

Iterative multiply/divide unit for the miniRV core, implementing the RV32M operations. It sits between the register-file read ports and the write-back path. It consumes the two source operands (rD1/rD2) plus the destination index, and produces a write-back value, destination index and one-cycle write enable for the register file. The core holds the instruction stalled while `busy` is high.

## Interface
- WIDTH, 32, operand/result width; only 32 is supported.
- cpu_clk  in  1  core clock, rising edge.
- cpu_rst  in  1  reset: asynchronous, active-high.
- start  in  1  request; sampled only in IDLE or DONE.
- op  in  3  funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- src_a  in  WIDTH  rs1 value (from rD1).
- src_b  in  WIDTH  rs2 value (from rD2).
- rd_in  in  5  destination register index.
- busy  out  1  high in CALC and FIX.
- done  out  1  high exactly in DONE.
- result  out  WIDTH  operation result; held after DONE until the next accepted start.
- rd_out  out  5  latched rd_in.
- we_out  out  1  equals done; drives the register-file write enable.

## Operation
- States:
  - IDLE → CALC on start.
  - DONE → CALC on start, otherwise DONE → IDLE.
  - CALC → FIX after 32 iterations.
  - FIX → DONE.
- Accept edge: latch op, rd_in, and the operand magnitudes:
  - signed operands converted to absolute value;
  - result-sign flag computed;
  - iteration counter cleared.
- Multiply: radix-2 shift-add, one bit of multiplier per CALC cycle, 64-bit product register.
  - MUL: low 32 bits.
  - MULH, MULHSU, MULHU: high 32 bits.
- Signedness of operands:
  - MULH: both signed.
  - MULHSU: src_a signed, src_b unsigned.
  - MULHU, DIVU, REMU: both unsigned.
  - DIV, REM: both signed.
- Divide: restoring, one quotient bit per CALC cycle, 33-bit partial remainder.
- Result signs:
  - quotient negated when operand signs differ;
  - remainder takes the sign of the dividend.
- FIX: applies the two's-complement sign correction and loads `result`.
- Fast path, accept → DONE in one cycle (no CALC/FIX):
  - divide by zero (src_b==0): DIV/DIVU → 0xFFFF_FFFF; REM/REMU → src_a.
  - signed overflow (DIV/REM with src_a=0x8000_0000, src_b=0xFFFF_FFFF): DIV → 0x8000_0000; REM → 0.
- start while busy: ignored. No queueing, and the operands in flight are unaffected.
- rd_out==0 still pulses we_out; the register file discards the write.

## Timing
- Reset, asynchronous: state=IDLE; busy=0, done=0, we_out=0, result=0, rd_out=0; counter=0.
- Reset mid-operation aborts immediately. No write is issued.
- Normal latency, accept at edge E0:
  - CALC during E0..E32;
  - FIX after E32;
  - DONE after E33 (done=1 for one cycle);
  - IDLE after E34 unless start.
- Fast-path latency: DONE after E1.
- start in DONE is accepted at that edge. done drops and busy rises on the next cycle, giving back-to-back issue with no IDLE gap.
- src_a, src_b, rd_in, op are required stable only at the accept edge.
- result, rd_out change only in FIX, on fast-path entry to DONE, or at reset.

## Configuration
- MDU_DIV_EN defined: full divider and all eight ops.
- MDU_DIV_EN undefined:
  - divider datapath is not compiled;
  - ops 4–7 take the fast path: accept → DONE in one cycle, result=0;
  - multiply ops are unchanged.

## Test plan
- MUL 7 × 6, rd=5 → busy for 33 cycles; done/we_out pulse once with result=42, rd_out=5; result still 42 two cycles later.
- MULH 0xFFFF_FFFF × 0xFFFF_FFFF → 0; MULHU same operands → 0xFFFF_FFFE; MULHSU 0xFFFF_FFFF × 2 → 0xFFFF_FFFF.
- DIV −7/2 → 0xFFFF_FFFD (−3); REM −7/2 → 0xFFFF_FFFF (−1); DIVU 100/7 → 14; REMU 100/7 → 2; each done at E33.
- DIV 5/0 → 0xFFFF_FFFF, REM 5/0 → 5, DIV 0x8000_0000/−1 → 0x8000_0000: done one cycle after accept, busy never high.
- start pulsed at E10 of a MUL (ignored); start held in DONE with new operands → next op accepted with no IDLE cycle and both results correct.
- cpu_rst asserted at E15 of a DIV → all outputs 0 asynchronously, no we_out pulse; next MUL 3 × 3 → 9. Repeat DIV 8/2 with MDU_DIV_EN undefined → result 0, done after one cycle.

Source files
------------

// File: rtl/mdu_iter.sv
// mdu_iter: iterative RV32M multiply/divide unit for the miniRV core.
//
// Radix-2 shift-add multiplier and restoring divider, one bit per cycle over
// 32 CALC cycles, followed by a single FIX cycle that applies the sign
// correction. Divide-by-zero and signed overflow finish directly in DONE.
//
// Build option:
//   MDU_DIV_EN  defined   -> divider compiled, all eight ops supported.
//               undefined -> ops 4-7 complete immediately with result 0.
//
// Ports:
//   cpu_clk  in   core clock, rising edge
//   cpu_rst  in   asynchronous active-high reset
//   start    in   request, sampled in IDLE or DONE only
//   op       in   funct3 (0 MUL .. 7 REMU)
//   src_a    in   rs1 operand
//   src_b    in   rs2 operand
//   rd_in    in   destination register index
//   busy     out  high while iterating (CALC) or correcting (FIX)
//   done     out  high for the single DONE cycle
//   result   out  result, held until the next accepted request
//   rd_out   out  destination index of result
//   we_out   out  register-file write enable (same as done)

module mdu_iter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             cpu_clk,
  input  logic             cpu_rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic [4:0]       rd_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [4:0]       rd_out,
  output logic             we_out
);

  localparam int unsigned CntW = $clog2(WIDTH);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StCalc = 2'd1;
  localparam logic [1:0] StFix  = 2'd2;
  localparam logic [1:0] StDone = 2'd3;

  localparam logic [2:0] OpMul    = 3'd0;
  localparam logic [2:0] OpMulh   = 3'd1;
  localparam logic [2:0] OpMulhsu = 3'd2;
  localparam logic [2:0] OpDiv    = 3'd4;
  localparam logic [2:0] OpDivu   = 3'd5;
  localparam logic [2:0] OpRem    = 3'd6;
  localparam logic [2:0] OpRemu   = 3'd7;

  logic [1:0]         state_q, state_d;
  logic [2:0]         op_q, op_d;
  logic [4:0]         rd_q, rd_d;
  logic               neg_q, neg_d;
  logic [WIDTH-1:0]   opm_q, opm_d;     // multiplicand (mul) or divisor (div) magnitude
  logic [2*WIDTH-1:0] prod_q, prod_d;   // product; low half is multiplier / quotient
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic [4:0]         rd_out_q, rd_out_d;

  logic               accept;
  logic               a_signed, b_signed, a_neg, b_neg, res_neg;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic               fast;
  logic [WIDTH-1:0]   fast_result;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_step;
  logic [2*WIDTH-1:0] prod_neg, prod_fix;
  logic [WIDTH-1:0]   fix_result;

`ifdef MDU_DIV_EN
  logic [WIDTH:0]     rem_q, rem_d;     // partial remainder
  logic [WIDTH:0]     rem_shift;
  logic [WIDTH+1:0]   rem_diff;
  logic               div_zero, div_ovf;
  logic [WIDTH-1:0]   quo_fix, rem_fix;
`endif

  assign accept = start & ((state_q == StIdle) | (state_q == StDone));

  // Operand signedness per funct3.
  always_comb begin
    a_signed = 1'b0;
    b_signed = 1'b0;
    case (op)
      OpMulh, OpDiv, OpRem: begin
        a_signed = 1'b1;
        b_signed = 1'b1;
      end
      OpMulhsu: a_signed = 1'b1;
      default: ;
    endcase
  end

  assign a_neg   = a_signed & src_a[WIDTH-1];
  assign b_neg   = b_signed & src_b[WIDTH-1];
  assign a_mag   = a_neg ? (~src_a + 1'b1) : src_a;
  assign b_mag   = b_neg ? (~src_b + 1'b1) : src_b;
  // Remainder follows the dividend; everything else follows the sign product.
  assign res_neg = (op == OpRem) ? a_neg : (a_neg ^ b_neg);

`ifdef MDU_DIV_EN
  assign div_zero = (src_b == '0);
  assign div_ovf  = ((op == OpDiv) | (op == OpRem)) &
                    (src_a == {1'b1, {(WIDTH-1){1'b0}}}) & (src_b == '1);
  assign fast     = op[2] & (div_zero | div_ovf);

  // op[1] separates REM/REMU from DIV/DIVU.
  always_comb begin
    if (div_zero) begin
      fast_result = op[1] ? src_a : '1;
    end else begin
      fast_result = op[1] ? '0 : {1'b1, {(WIDTH-1){1'b0}}};
    end
  end
`else
  assign fast        = op[2];
  assign fast_result = '0;
`endif

  // One shift-add step: add multiplicand into the upper half when the current
  // multiplier bit is set, then shift the whole register right by one.
  assign mul_sum  = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + {1'b0, opm_q};
  assign mul_step = prod_q[0] ? {mul_sum, prod_q[WIDTH-1:1]}
                              : {1'b0, prod_q[2*WIDTH-1:1]};

`ifdef MDU_DIV_EN
  // One restoring step: shift the next dividend bit in, trial-subtract.
  assign rem_shift = {rem_q[WIDTH-1:0], prod_q[WIDTH-1]};
  assign rem_diff  = {rem_q, prod_q[WIDTH-1]} - {2'b00, opm_q};
`endif

  // Sign correction applied in FIX.
  assign prod_neg = ~prod_q + 1'b1;
  assign prod_fix = neg_q ? prod_neg : prod_q;

`ifdef MDU_DIV_EN
  assign quo_fix = neg_q ? (~prod_q[WIDTH-1:0] + 1'b1) : prod_q[WIDTH-1:0];
  assign rem_fix = neg_q ? (~rem_q[WIDTH-1:0] + 1'b1) : rem_q[WIDTH-1:0];

  always_comb begin
    case (op_q)
      OpMul:          fix_result = prod_fix[WIDTH-1:0];
      OpDiv, OpDivu:  fix_result = quo_fix;
      OpRem, OpRemu:  fix_result = rem_fix;
      default:        fix_result = prod_fix[2*WIDTH-1:WIDTH];
    endcase
  end
`else
  always_comb begin
    case (op_q)
      OpMul:   fix_result = prod_fix[WIDTH-1:0];
      default: fix_result = prod_fix[2*WIDTH-1:WIDTH];
    endcase
  end
`endif

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    rd_d     = rd_q;
    neg_d    = neg_q;
    opm_d    = opm_q;
    prod_d   = prod_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    rd_out_d = rd_out_q;
`ifdef MDU_DIV_EN
    rem_d    = rem_q;
`endif
    case (state_q)
      StIdle, StDone: begin
        state_d = StIdle;
        if (accept) begin
          op_d  = op;
          rd_d  = rd_in;
          neg_d = res_neg;
          cnt_d = '0;
          if (fast) begin
            state_d  = StDone;
            result_d = fast_result;
            rd_out_d = rd_in;
          end else begin
            state_d = StCalc;
`ifdef MDU_DIV_EN
            opm_d  = op[2] ? b_mag : a_mag;
            prod_d = {{WIDTH{1'b0}}, (op[2] ? a_mag : b_mag)};
            rem_d  = '0;
`else
            opm_d  = a_mag;
            prod_d = {{WIDTH{1'b0}}, b_mag};
`endif
          end
        end
      end
      StCalc: begin
        cnt_d = cnt_q + 1'b1;
`ifdef MDU_DIV_EN
        if (op_q[2]) begin
          prod_d = {prod_q[2*WIDTH-1:WIDTH], prod_q[WIDTH-2:0], ~rem_diff[WIDTH+1]};
          rem_d  = rem_diff[WIDTH+1] ? rem_shift : rem_diff[WIDTH:0];
        end else begin
          prod_d = mul_step;
        end
`else
        prod_d = mul_step;
`endif
        if (cnt_q == CntW'(WIDTH - 1)) begin
          state_d = StFix;
        end
      end
      StFix: begin
        state_d  = StDone;
        result_d = fix_result;
        rd_out_d = rd_q;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge cpu_clk or posedge cpu_rst) begin
    if (cpu_rst) begin
      state_q  <= StIdle;
      op_q     <= '0;
      rd_q     <= '0;
      neg_q    <= 1'b0;
      opm_q    <= '0;
      prod_q   <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      rd_out_q <= '0;
`ifdef MDU_DIV_EN
      rem_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      rd_q     <= rd_d;
      neg_q    <= neg_d;
      opm_q    <= opm_d;
      prod_q   <= prod_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      rd_out_q <= rd_out_d;
`ifdef MDU_DIV_EN
      rem_q    <= rem_d;
`endif
    end
  end

  assign busy   = (state_q == StCalc) | (state_q == StFix);
  assign done   = (state_q == StDone);
  assign we_out = done;
  assign result = result_q;
  assign rd_out = rd_out_q;

endmodule

// File: tb/tb_mdu_iter.sv
// Self-checking bench for mdu_iter: a latency/arithmetic reference model is
// compared against the DUT every falling edge, and directed vectors carry
// hand-computed literal expectations.

module tb_mdu_iter;

`ifdef MDU_DIV_EN
  localparam bit DivEn = 1'b1;
`else
  localparam bit DivEn = 1'b0;
`endif

  logic        cpu_clk = 1'b0;
  logic        cpu_rst = 1'b1;
  logic        start   = 1'b0;
  logic [2:0]  op      = 3'd0;
  logic [31:0] src_a   = 32'd0;
  logic [31:0] src_b   = 32'd0;
  logic [4:0]  rd_in   = 5'd0;
  logic        busy, done, we_out;
  logic [31:0] result;
  logic [4:0]  rd_out;

  int n_cmp = 0;
  int n_bad = 0;

  mdu_iter #(.WIDTH(32)) dut (
    .cpu_clk (cpu_clk),
    .cpu_rst (cpu_rst),
    .start   (start),
    .op      (op),
    .src_a   (src_a),
    .src_b   (src_b),
    .rd_in   (rd_in),
    .busy    (busy),
    .done    (done),
    .result  (result),
    .rd_out  (rd_out),
    .we_out  (we_out)
  );

  always #5 cpu_clk = ~cpu_clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, want 0x%08h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference arithmetic straight from the RV32M definitions.
  function automatic logic [31:0] ref_res(input logic [2:0] o, input logic [31:0] a,
                                          input logic [31:0] b);
    logic signed [63:0] sa, sb, ua, ub;
    logic signed [31:0] a32, b32, q32;
    logic [63:0] p;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'd0, a};
    ub = {32'd0, b};
    a32 = a;
    b32 = b;
    if (!DivEn && o[2]) return 32'd0;
    case (o)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        q32 = a32 / b32;
        return q32;
      end
      3'd5: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 32'd0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        q32 = a32 % b32;
        return q32;
      end
      default: return (b == 32'd0) ? a : a % b;
    endcase
  endfunction

  function automatic bit ref_fast(input logic [2:0] o, input logic [31:0] a,
                                  input logic [31:0] b);
    if (!o[2]) return 1'b0;
    if (!DivEn) return 1'b1;
    if (b == 32'd0) return 1'b1;
    return (o == 3'd4 || o == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF;
  endfunction

  // Model: an accepted op is busy for 33 cycles then done for one,
  // or done immediately on the fast path.
  int          m_left = 0;
  logic        m_done = 1'b0;
  logic [31:0] m_res  = 32'd0;
  logic [31:0] p_res  = 32'd0;
  logic [4:0]  m_rd   = 5'd0;
  logic [4:0]  p_rd   = 5'd0;

  always @(posedge cpu_clk or posedge cpu_rst) begin
    if (cpu_rst) begin
      m_left <= 0;
      m_done <= 1'b0;
      m_res  <= 32'd0;
      m_rd   <= 5'd0;
    end else if (start && m_left == 0) begin
      if (ref_fast(op, src_a, src_b)) begin
        m_done <= 1'b1;
        m_res  <= ref_res(op, src_a, src_b);
        m_rd   <= rd_in;
      end else begin
        m_done <= 1'b0;
        m_left <= 33;
        p_res  <= ref_res(op, src_a, src_b);
        p_rd   <= rd_in;
      end
    end else if (m_left > 0) begin
      m_left <= m_left - 1;
      if (m_left == 1) begin
        m_done <= 1'b1;
        m_res  <= p_res;
        m_rd   <= p_rd;
      end
    end else begin
      m_done <= 1'b0;
    end
  end

  always @(negedge cpu_clk) begin
    chk("cyc_busy", 32'(busy), 32'(m_left != 0));
    chk("cyc_done", 32'(done), 32'(m_done));
    chk("cyc_we", 32'(we_out), 32'(m_done));
    chk("cyc_result", result, m_res);
    chk("cyc_rd", 32'(rd_out), 32'(m_rd));
  end

  // Request for one cycle; returns at the falling edge after the accept edge.
  task automatic issue(input bit now, input logic [2:0] o, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] r);
    if (!now) @(negedge cpu_clk);
    start = 1'b1;
    op    = o;
    src_a = a;
    src_b = b;
    rd_in = r;
    @(negedge cpu_clk);
    start = 1'b0;
    op    = 3'($urandom);
    src_a = $urandom;
    src_b = $urandom;
    rd_in = 5'($urandom);
  endtask

  // k counts falling edges after the accept edge; done is due at k=33 (or 0).
  task automatic wait_done(input int k0, input bit fast, input string nm);
    int k;
    int nb;
    k  = k0;
    nb = busy ? 1 : 0;
    while (!done && k < 40) begin
      @(negedge cpu_clk);
      k++;
      if (busy) nb++;
    end
    chk({nm, "_done"}, 32'(done), 32'd1);
    chk({nm, "_latency"}, 32'(k), fast ? 32'd0 : 32'd33);
    chk({nm, "_busycycles"}, 32'(nb), fast ? 32'd0 : 32'(33 - k0));
  endtask

  task automatic run_op(input bit now, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] r,
                        input logic [31:0] exp_res, input bit fast, input string nm);
    issue(now, o, a, b, r);
    wait_done(0, fast, nm);
    chk({nm, "_result"}, result, exp_res);
    chk({nm, "_rd"}, 32'(rd_out), 32'(r));
    chk({nm, "_we"}, 32'(we_out), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int nwe;
    @(negedge cpu_clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_we", 32'(we_out), 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_rd", 32'(rd_out), 32'd0);
    cpu_rst = 1'b0;
    repeat (2) @(negedge cpu_clk);

    // Multiply.
    run_op(1'b0, 3'd0, 32'd7, 32'd6, 5'd5, 32'd42, 1'b0, "mul_7x6");
    repeat (2) @(negedge cpu_clk);
    chk("mul_hold_result", result, 32'd42);
    chk("mul_hold_rd", 32'(rd_out), 32'd5);
    run_op(1'b0, 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1, 32'h0000_0000, 1'b0, "mulh_m1");
    run_op(1'b0, 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 32'hFFFF_FFFE, 1'b0, "mulhu_max");
    run_op(1'b0, 3'd2, 32'hFFFF_FFFF, 32'd2, 5'd3, 32'hFFFF_FFFF, 1'b0, "mulhsu_m1x2");
    run_op(1'b0, 3'd0, 32'hFFFF_FFFD, 32'd5, 5'd4, 32'hFFFF_FFF1, 1'b0, "mul_m3x5");
    run_op(1'b0, 3'd1, 32'h8000_0000, 32'h8000_0000, 5'd6, 32'h4000_0000, 1'b0, "mulh_min");

    // Divide (fast path with result 0 when the divider is not built).
    run_op(1'b0, 3'd4, 32'hFFFF_FFF9, 32'd2, 5'd11, DivEn ? 32'hFFFF_FFFD : 32'd0,
           !DivEn, "div_m7_2");
    run_op(1'b0, 3'd6, 32'hFFFF_FFF9, 32'd2, 5'd12, DivEn ? 32'hFFFF_FFFF : 32'd0,
           !DivEn, "rem_m7_2");
    run_op(1'b0, 3'd5, 32'd100, 32'd7, 5'd13, DivEn ? 32'd14 : 32'd0, !DivEn, "divu_100_7");
    run_op(1'b0, 3'd7, 32'd100, 32'd7, 5'd14, DivEn ? 32'd2 : 32'd0, !DivEn, "remu_100_7");

    // Divide fast-path corners.
    run_op(1'b0, 3'd4, 32'd5, 32'd0, 5'd15, DivEn ? 32'hFFFF_FFFF : 32'd0, 1'b1, "div_5_0");
    run_op(1'b0, 3'd6, 32'd5, 32'd0, 5'd16, DivEn ? 32'd5 : 32'd0, 1'b1, "rem_5_0");
    run_op(1'b0, 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd17,
           DivEn ? 32'h8000_0000 : 32'd0, 1'b1, "div_ovf");
    run_op(1'b0, 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd18, 32'd0, 1'b1, "rem_ovf");

    // start while busy is ignored.
    issue(1'b0, 3'd0, 32'h0000_1234, 32'h10, 5'd7);
    repeat (9) @(negedge cpu_clk);
    start = 1'b1;
    op    = 3'd5;
    src_a = 32'd1;
    src_b = 32'd1;
    rd_in = 5'd9;
    @(negedge cpu_clk);
    start = 1'b0;
    wait_done(10, 1'b0, "busy_ignore");
    chk("busy_ignore_result", result, 32'h0001_2340);
    chk("busy_ignore_rd", 32'(rd_out), 32'd7);
    @(negedge cpu_clk);
    chk("busy_ignore_no_second", 32'(done | busy), 32'd0);

    // Back-to-back issue from DONE.
    run_op(1'b0, 3'd0, 32'd3, 32'd5, 5'd8, 32'd15, 1'b0, "b2b_first");
    issue(1'b1, 3'd3, 32'h0001_0000, 32'h0001_0000, 5'd9);
    chk("b2b_busy", 32'(busy), 32'd1);
    chk("b2b_done", 32'(done), 32'd0);
    wait_done(0, 1'b0, "b2b_second");
    chk("b2b_second_result", result, 32'd1);
    chk("b2b_second_rd", 32'(rd_out), 32'd9);

    // Asynchronous reset in the middle of a divide.
    issue(1'b0, 3'd4, 32'd1000, 32'd3, 5'd10);
    repeat (14) @(negedge cpu_clk);
    @(posedge cpu_clk);
    #2 cpu_rst = 1'b1;
    #1;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_done", 32'(done), 32'd0);
    chk("arst_we", 32'(we_out), 32'd0);
    chk("arst_result", result, 32'd0);
    chk("arst_rd", 32'(rd_out), 32'd0);
    repeat (2) @(negedge cpu_clk);
    cpu_rst = 1'b0;
    nwe = 0;
    repeat (40) begin
      @(negedge cpu_clk);
      if (we_out) nwe++;
    end
    chk("arst_no_write", 32'(nwe), 32'd0);
    run_op(1'b0, 3'd0, 32'd3, 32'd3, 5'd19, 32'd9, 1'b0, "mul_after_rst");

    run_op(1'b0, 3'd4, 32'd8, 32'd2, 5'd20, DivEn ? 32'd4 : 32'd0, !DivEn, "div_8_2");

    repeat (3) @(negedge cpu_clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
